fetch_unit: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the 5-stage WISC pipeline. Produces the ins and PC_2 values consumed by the decode stage. Accepts decode's redirect (branch, nextPC), stall and halt. Talks to a multi-cycle instruction memory over a req/ready handshake.

---
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_fetch_unit.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// WISC instruction fetch stage with IF/ID register and multi-cycle imem handshake.
// Optional FETCH_PERF_CNT_EN adds saturating perf_wait / perf_flush counters.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INS  = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  input  logic        imem_err,
  input  logic        stall,
  input  logic        branch,
  input  logic [15:0] nextPC,
  input  logic        halt_fetch,
  output logic [15:0] ins,
  output logic [15:0] PC_2,
  output logic        ins_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0] perf_wait,
  output logic [15:0] perf_flush,
`endif
  output logic        err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] HOLD   = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] HALTED = 3'd4;

  logic [2:0]  state;
  logic [15:0] addr;
  logic [15:0] tgt;
  logic [15:0] hold_ins;
  logic        pend;

  logic hlt;
  logic redir;
  logic odd;
  logic live;

  assign hlt   = halt_fetch & ~stall;
  assign redir = branch & ~stall & ~halt_fetch;
  assign odd   = nextPC[0];
  assign live  = (state == IDLE) | (state == FETCH) | (state == HOLD);

  assign imem_req  = (state == FETCH) | (state == DRAIN);
  assign imem_addr = addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr      <= RESET_PC;
      tgt       <= RESET_PC;
      hold_ins  <= NOP_INS;
      pend      <= 1'b0;
      ins       <= NOP_INS;
      PC_2      <= 16'h0000;
      ins_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hlt) begin
            state <= HALTED;
          end else if (redir & odd) begin
            err   <= 1'b1;
            state <= HALTED;
          end else if (redir) begin
            addr  <= nextPC;
            state <= FETCH;
          end else begin
            state <= FETCH;
          end
        end
        FETCH: begin
          if (hlt | redir) begin
            ins       <= NOP_INS;
            ins_valid <= 1'b0;
            if (redir & odd) err <= 1'b1;
            // An unanswered request must be drained before moving on
            if (!imem_ready) begin
              state <= DRAIN;
              pend  <= hlt | odd;
              tgt   <= nextPC;
            end else if (hlt | odd) begin
              state <= HALTED;
            end else begin
              addr <= nextPC;
            end
          end else if (imem_ready & imem_err) begin
            err       <= 1'b1;
            ins       <= NOP_INS;
            ins_valid <= 1'b0;
            state     <= HALTED;
          end else if (imem_ready & stall) begin
            hold_ins <= imem_data;
            addr     <= addr + 16'd2;
            state    <= HOLD;
          end else if (imem_ready) begin
            ins       <= imem_data;
            PC_2      <= addr + 16'd2;
            ins_valid <= 1'b1;
            addr      <= addr + 16'd2;
          end else if (!stall) begin
            ins       <= NOP_INS;
            ins_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (hlt | redir) begin
            ins       <= NOP_INS;
            ins_valid <= 1'b0;
            if (hlt | odd) begin
              err   <= err | (redir & odd);
              state <= HALTED;
            end else begin
              addr  <= nextPC;
              state <= FETCH;
            end
          end else if (!stall) begin
            // addr already advanced past the buffered fetch
            ins       <= hold_ins;
            PC_2      <= addr;
            ins_valid <= 1'b1;
            state     <= FETCH;
          end
        end
        DRAIN: begin
          if (hlt) pend <= 1'b1;
          if (imem_ready) begin
            if (pend | hlt) begin
              state <= HALTED;
            end else begin
              addr  <= tgt;
              state <= FETCH;
            end
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_wait  <= 16'h0000;
      perf_flush <= 16'h0000;
    end else begin
      if (imem_req & ~imem_ready & (perf_wait != 16'hFFFF))
        perf_wait <= perf_wait + 16'd1;
      if (redir & live & (perf_flush != 16'hFFFF))
        perf_flush <= perf_flush + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, directed corner sequences,
// and a randomized run checked against an instruction-stream reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic        imem_err;
  logic        stall;
  logic        branch;
  logic [15:0] nextPC;
  logic        halt_fetch;
  logic [15:0] ins;
  logic [15:0] PC_2;
  logic        ins_valid;
  logic        err;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_wait;
  logic [15:0] perf_flush;
`endif

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_data  (imem_data),
    .imem_err   (imem_err),
    .stall      (stall),
    .branch     (branch),
    .nextPC     (nextPC),
    .halt_fetch (halt_fetch),
    .ins        (ins),
    .PC_2       (PC_2),
    .ins_valid  (ins_valid),
`ifdef FETCH_PERF_CNT_EN
    .perf_wait  (perf_wait),
    .perf_flush (perf_flush),
`endif
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'h4001 + {1'b0, a[15:1]};
  endfunction

  // Memory model: per-request wait count, fixed or random
  int          waits    = 0;
  bit          rnd_mode = 0;
  bit          err_en   = 0;
  logic [15:0] err_addr = 16'h0000;
  int          wcnt     = 0;
  int          cur_wait = 0;
  bit          started  = 0;
  logic [15:0] last_addr = 16'h0000;

  always @(negedge clk) begin
    #1;
    if (!imem_req) begin
      imem_ready = 1'b0;
      imem_data  = 16'hDEAD;
      imem_err   = 1'b0;
      wcnt       = 0;
      started    = 0;
    end else begin
      if (started && !imem_ready)
        chk("addr_stable", {16'h0, imem_addr}, {16'h0, last_addr});
      if (imem_ready || !started) begin
        wcnt     = 0;
        cur_wait = rnd_mode ? int'($urandom_range(0, 3)) : waits;
        started  = 1;
      end
      imem_ready = (wcnt == cur_wait);
      if (!imem_ready) wcnt++;
      imem_data = imem_ready ? mem_word(imem_addr) : 16'hDEAD;
      imem_err  = imem_ready && err_en && (imem_addr == err_addr);
      last_addr = imem_addr;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Async reset mid-cycle, then release on a falling edge
  task automatic reset_dut();
    stall = 0; branch = 0; nextPC = 0; halt_fetch = 0;
    #2 rst = 1'b0;
    #1 chk("rst_req_drop", {31'h0, imem_req}, 32'h0);
    tick();
    tick();
    rst = 1'b1;
  endtask

  typedef struct {
    logic        stall;
    logic        req;
    logic [15:0] addr;
    logic [15:0] ins;
    logic [15:0] pc2;
    logic        valid;
  } vec_t;

  vec_t tbl[8];

  logic        p_stall;
  logic [15:0] p_ins, p_pc2;
  logic        p_valid;
  logic [15:0] exp_pc2;
  logic [15:0] t;
  bit          s, b;
  int          ndel;

  initial begin
    tbl[0] = '{1'b0, 1'b1, 16'h0000, 16'h0800, 16'h0000, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 16'h0002, 16'h4001, 16'h0002, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 16'h0004, 16'h4002, 16'h0004, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 16'h0006, 16'h4002, 16'h0004, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 16'h0006, 16'h4002, 16'h0004, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 16'h0006, 16'h4002, 16'h0004, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 16'h0006, 16'h4003, 16'h0006, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 16'h0008, 16'h4004, 16'h0008, 1'b1};

    rst = 1'b1;
    stall = 0; branch = 0; nextPC = 0; halt_fetch = 0;
    imem_ready = 0; imem_data = 0; imem_err = 0;
    tick();

    // Reset state
    waits = 0;
    stall = 0; branch = 0; nextPC = 0; halt_fetch = 0;
    rst = 1'b0;
    tick();
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_ins", {16'h0, ins}, 32'h0800);
    chk("rst_pc2", {16'h0, PC_2}, 32'h0);
    chk("rst_valid", {31'h0, ins_valid}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_wait", {16'h0, perf_wait}, 32'h0);
    chk("rst_perf_flush", {16'h0, perf_flush}, 32'h0);
`endif
    rst = 1'b1;
    chk("idle_req", {31'h0, imem_req}, 32'h0);

    // Vector table: 0-wait start-up and a 3-cycle stall over a response
    for (int i = 0; i < 8; i++) begin
      stall = tbl[i].stall;
      tick();
      chk($sformatf("tbl%0d_req", i), {31'h0, imem_req}, {31'h0, tbl[i].req});
      if (tbl[i].req)
        chk($sformatf("tbl%0d_addr", i), {16'h0, imem_addr}, {16'h0, tbl[i].addr});
      chk($sformatf("tbl%0d_ins", i), {16'h0, ins}, {16'h0, tbl[i].ins});
      chk($sformatf("tbl%0d_valid", i), {31'h0, ins_valid}, {31'h0, tbl[i].valid});
      if (tbl[i].valid)
        chk($sformatf("tbl%0d_pc2", i), {16'h0, PC_2}, {16'h0, tbl[i].pc2});
    end

    // 2-wait memory: address held 3 cycles, two bubbles per instruction
    waits = 2;
    reset_dut();
    tick();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 3; c++) begin
        chk("w2_req", {31'h0, imem_req}, 32'h1);
        chk("w2_addr", {16'h0, imem_addr}, 32'(2 * k));
        if (c > 0) chk("w2_bubble", {31'h0, ins_valid}, 32'h0);
        if (c > 0) chk("w2_nop", {16'h0, ins}, 32'h0800);
        tick();
      end
      chk("w2_valid", {31'h0, ins_valid}, 32'h1);
      chk("w2_ins", {16'h0, ins}, {16'h0, mem_word(16'(2 * k))});
      chk("w2_pc2", {16'h0, PC_2}, 32'(2 * k + 2));
    end

    // Redirect while a 2-wait fetch of 0x0010 is outstanding (faulty response)
    waits = 0; err_en = 1; err_addr = 16'h0010;
    reset_dut();
    tick();
    branch = 1; nextPC = 16'h0010;
    tick();
    branch = 0; waits = 2;
    chk("br_addr10", {16'h0, imem_addr}, 32'h0010);
    chk("br_bubble0", {31'h0, ins_valid}, 32'h0);
    tick();
    branch = 1; nextPC = 16'h0100;
    tick();
    branch = 0;
    chk("drain_req", {31'h0, imem_req}, 32'h1);
    chk("drain_addr", {16'h0, imem_addr}, 32'h0010);
    chk("drain_bubble", {31'h0, ins_valid}, 32'h0);
    tick();
    for (int c = 0; c < 3; c++) begin
      chk("redir_addr", {16'h0, imem_addr}, 32'h0100);
      chk("redir_no_old", {31'h0, ins_valid}, 32'h0);
      tick();
    end
    chk("redir_valid", {31'h0, ins_valid}, 32'h1);
    chk("redir_ins", {16'h0, ins}, {16'h0, mem_word(16'h0100)});
    chk("redir_pc2", {16'h0, PC_2}, 32'h0102);
    chk("drain_err_ignored", {31'h0, err}, 32'h0);
    err_en = 0;

    // PC wrap 0xFFFE -> 0x0000
    waits = 0;
    reset_dut();
    tick();
    branch = 1; nextPC = 16'hFFFE;
    tick();
    branch = 0;
    chk("wrap_addr", {16'h0, imem_addr}, 32'hFFFE);
    tick();
    chk("wrap_ins", {16'h0, ins}, {16'h0, mem_word(16'hFFFE)});
    chk("wrap_pc2", {16'h0, PC_2}, 32'h0000);
    chk("wrap_next", {16'h0, imem_addr}, 32'h0000);
    chk("wrap_err", {31'h0, err}, 32'h0);

    // Halt with 0-wait: no further requests for 20 cycles
    reset_dut();
    tick();
    halt_fetch = 1;
    tick();
    halt_fetch = 0;
    for (int c = 0; c < 20; c++) begin
      chk("halt_req", {31'h0, imem_req}, 32'h0);
      chk("halt_valid", {31'h0, ins_valid}, 32'h0);
      tick();
    end
    chk("halt_ins", {16'h0, ins}, 32'h0800);
    reset_dut();
    tick();
    chk("restart_req", {31'h0, imem_req}, 32'h1);
    chk("restart_addr", {16'h0, imem_addr}, 32'h0000);

    // Halt while a 2-wait request is outstanding goes through DRAIN
    waits = 2;
    reset_dut();
    tick();
    halt_fetch = 1;
    tick();
    halt_fetch = 0;
    chk("hdrain_req", {31'h0, imem_req}, 32'h1);
    tick();
    chk("hdrain_req2", {31'h0, imem_req}, 32'h1);
    tick();
    chk("hdrain_done", {31'h0, imem_req}, 32'h0);
    chk("hdrain_valid", {31'h0, ins_valid}, 32'h0);

    // Kept response with imem_err
    waits = 0; err_en = 1; err_addr = 16'h0004;
    reset_dut();
    for (int c = 0; c < 4; c++) tick();
    chk("ierr_err", {31'h0, err}, 32'h1);
    chk("ierr_req", {31'h0, imem_req}, 32'h0);
    chk("ierr_valid", {31'h0, ins_valid}, 32'h0);
    for (int c = 0; c < 5; c++) tick();
    chk("ierr_sticky", {31'h0, err}, 32'h1);
    chk("ierr_halted", {31'h0, imem_req}, 32'h0);
    err_en = 0;

    // Branch to odd address
    reset_dut();
    chk("rst_clears_err", {31'h0, err}, 32'h0);
    tick();
    branch = 1; nextPC = 16'h0101;
    tick();
    branch = 0;
    chk("odd_err", {31'h0, err}, 32'h1);
    chk("odd_req", {31'h0, imem_req}, 32'h0);
    chk("odd_valid", {31'h0, ins_valid}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("odd_perf_flush", {16'h0, perf_flush}, 32'h1);
`endif
    for (int c = 0; c < 4; c++) tick();
    chk("odd_sticky", {31'h0, err}, 32'h1);
    chk("odd_no_fetch", {31'h0, imem_req}, 32'h0);

    // Random run against the instruction-stream model
    rnd_mode = 1;
    reset_dut();
    exp_pc2 = 16'h0002;
    ndel    = 0;
    p_stall = 0; p_ins = ins; p_pc2 = PC_2; p_valid = ins_valid;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (p_stall) begin
        chk("rnd_hold_ins", {16'h0, ins}, {16'h0, p_ins});
        chk("rnd_hold_valid", {31'h0, ins_valid}, {31'h0, p_valid});
        chk("rnd_hold_pc2", {16'h0, PC_2}, {16'h0, p_pc2});
      end
      s = ($urandom_range(0, 9) < 3);
      b = 0;
      t = 16'h0000;
      if (!s && ins_valid) begin
        chk("rnd_pc2", {16'h0, PC_2}, {16'h0, exp_pc2});
        chk("rnd_ins", {16'h0, ins}, {16'h0, mem_word(PC_2 - 16'd2)});
        exp_pc2 = exp_pc2 + 16'd2;
        ndel++;
        if ($urandom_range(0, 9) == 0) begin
          b = 1;
          t = 16'($urandom) & 16'hFFFE;
          exp_pc2 = t + 16'd2;
        end
      end else if (s && $urandom_range(0, 9) == 0) begin
        b = 1;
        t = 16'($urandom) | 16'h0001;
      end
      p_stall = s; p_ins = ins; p_pc2 = PC_2; p_valid = ins_valid;
      stall = s; branch = b; nextPC = t;
      tick();
    end
    stall = 0; branch = 0;
    chk("rnd_progress", {31'h0, ndel > 200}, 32'h1);
    chk("rnd_err", {31'h0, err}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
